// File: rtl/peripheral_uart_pkg.sv
// Shared constants and types for the peripheral_uart APB host: register map,
// bit positions inside LCR/LSR, FIFO control init value and FSM encodings.
package peripheral_uart_pkg;

  localparam logic [2:0] OFF_THR = 3'd0;
  localparam logic [2:0] OFF_RBR = 3'd0;
  localparam logic [2:0] OFF_DLL = 3'd0;
  localparam logic [2:0] OFF_IER = 3'd1;
  localparam logic [2:0] OFF_DLM = 3'd1;
  localparam logic [2:0] OFF_FCR = 3'd2;
  localparam logic [2:0] OFF_LCR = 3'd3;
  localparam logic [2:0] OFF_LSR = 3'd5;

  localparam int LCR_DLAB = 7;
  localparam int LSR_DR   = 0;
  localparam int LSR_PE   = 2;
  localparam int LSR_THRE = 5;

  // Clear both FIFOs, RX trigger level 00.
  localparam logic [7:0] FCR_INIT = 8'h06;
  localparam logic [7:0] IER_INIT = 8'h00;

  typedef enum logic [3:0] {
    ST_W_LCRD,
    ST_W_DLL,
    ST_W_DLM,
    ST_W_LCR,
    ST_W_FCR,
    ST_W_IER,
    ST_POLL,
    ST_DECIDE,
    ST_R_RBR,
    ST_W_THR
  } host_state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_phase_e;

endpackage

// File: rtl/peripheral_uart_apb_master_port.sv
// APB initiator sequencer: turns a held req into one SETUP/ACCESS transfer
// followed by at least one IDLE cycle; done pulses on the completing ACCESS cycle.
module peripheral_uart_apb_master_port
  import peripheral_uart_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          req,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          write,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  output logic          PWRITE,
  output logic          PSEL,
  output logic          PENABLE,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  apb_phase_e phase, phase_nxt;

  always_comb begin
    phase_nxt = phase;
    case (phase)
      APB_IDLE:   if (req) phase_nxt = APB_SETUP;
      APB_SETUP:  phase_nxt = APB_ACCESS;
      APB_ACCESS: if (PREADY) phase_nxt = APB_IDLE;
      default:    phase_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) phase <= APB_IDLE;
    else       phase <= phase_nxt;
  end

  // Address/data/direction captured at SETUP entry and held through ACCESS.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
    end else if (phase == APB_IDLE && req) begin
      PADDR  <= addr;
      PWDATA <= wdata;
      PWRITE <= write;
    end
  end

  // Decoded from the phase register so an async reset drops them at once.
  assign PSEL    = (phase != APB_IDLE);
  assign PENABLE = (phase == APB_ACCESS);
  assign done    = PENABLE && PREADY;
  assign rdata   = PRDATA;
  assign err     = PSLVERR;

endmodule

// File: rtl/peripheral_uart_apb_host.sv
// Programs a peripheral_uart over APB after reset, then polls LSR and bridges
// a valid/ready TX byte stream into THR and RBR into a one-entry RX stream.
module peripheral_uart_apb_host
  import peripheral_uart_pkg::*;
#(
  parameter int          APB_ADDR_WIDTH = 12,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          UART_BASE      = 0,
  parameter logic [15:0] DIVISOR        = 16'd27,
  parameter logic [7:0]  LCR_CFG        = 8'h03,
  parameter int          TX_FIFO_DEPTH  = 16
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  input  logic [7:0]                tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  output logic [7:0]                rx_data_o,
  output logic                      rx_perr_o,
  output logic                      rx_valid_o,
  input  logic                      rx_ready_i,
  output logic                      init_done_o,
  output logic                      slverr_o
);

  localparam int             CW           = $clog2(TX_FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  CREDIT_FULL  = CW'(TX_FIFO_DEPTH);
  localparam logic [7:0]     LCR_FMT      = {1'b0, LCR_CFG[6:0]};
  localparam logic [7:0]     LCR_DLAB_SET = LCR_FMT | (8'h01 << LCR_DLAB);

  host_state_e state, state_nxt;

  logic                      req;
  logic                      write;
  logic [2:0]                off;
  logic [7:0]                wbyte;
  logic                      done;
  logic                      err;
  logic [APB_DATA_WIDTH-1:0] rdata;
  logic [7:0]                lsr_q;
  logic [7:0]                tx_byte_q;
  logic [CW-1:0]             credit_q;
  logic                      tx_take;
  logic                      rx_pending;
  logic                      unused_rdata_hi;

  assign unused_rdata_hi = ^rdata[APB_DATA_WIDTH-1:8];

  // RX wins over TX so a full responder RX FIFO drains first.
  assign rx_pending = lsr_q[LSR_DR] && !rx_valid_o;

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    write      = 1'b0;
    off        = OFF_LSR;
    wbyte      = 8'h00;
    tx_ready_o = 1'b0;
    tx_take    = 1'b0;
    case (state)
      ST_W_LCRD: begin
        req = 1'b1; write = 1'b1; off = OFF_LCR; wbyte = LCR_DLAB_SET;
        if (done) state_nxt = ST_W_DLL;
      end
      ST_W_DLL: begin
        req = 1'b1; write = 1'b1; off = OFF_DLL; wbyte = DIVISOR[7:0];
        if (done) state_nxt = ST_W_DLM;
      end
      ST_W_DLM: begin
        req = 1'b1; write = 1'b1; off = OFF_DLM; wbyte = DIVISOR[15:8];
        if (done) state_nxt = ST_W_LCR;
      end
      ST_W_LCR: begin
        req = 1'b1; write = 1'b1; off = OFF_LCR; wbyte = LCR_FMT;
        if (done) state_nxt = ST_W_FCR;
      end
      ST_W_FCR: begin
        req = 1'b1; write = 1'b1; off = OFF_FCR; wbyte = FCR_INIT;
        if (done) state_nxt = ST_W_IER;
      end
      ST_W_IER: begin
        req = 1'b1; write = 1'b1; off = OFF_IER; wbyte = IER_INIT;
        if (done) state_nxt = ST_POLL;
      end
      ST_POLL: begin
        req = 1'b1; off = OFF_LSR;
        if (done) state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (rx_pending) begin
          state_nxt = ST_R_RBR;
        end else if (credit_q != '0) begin
          tx_ready_o = 1'b1;
          if (tx_valid_i) begin
            tx_take   = 1'b1;
            state_nxt = ST_W_THR;
          end else begin
            state_nxt = ST_POLL;
          end
        end else begin
          state_nxt = ST_POLL;
        end
      end
      ST_R_RBR: begin
        req = 1'b1; off = OFF_RBR;
        if (done) state_nxt = ST_POLL;
      end
      ST_W_THR: begin
        req = 1'b1; write = 1'b1; off = OFF_THR; wbyte = tx_byte_q;
        if (done) state_nxt = ST_DECIDE;
      end
      default: state_nxt = ST_W_LCRD;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_W_LCRD;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lsr_q       <= 8'h00;
      tx_byte_q   <= 8'h00;
      credit_q    <= '0;
      rx_data_o   <= 8'h00;
      rx_perr_o   <= 1'b0;
      rx_valid_o  <= 1'b0;
      init_done_o <= 1'b0;
      slverr_o    <= 1'b0;
    end else begin
      // Credit is reloaded, not accumulated: THRE means the TX FIFO is empty.
      if (state == ST_POLL && done) begin
        lsr_q <= rdata[7:0];
        if (rdata[LSR_THRE]) credit_q <= CREDIT_FULL;
      end
      if (tx_take) begin
        tx_byte_q <= tx_data_i;
        credit_q  <= credit_q - CW'(1);
      end
      if (state == ST_R_RBR && done) begin
        rx_data_o  <= rdata[7:0];
        rx_perr_o  <= lsr_q[LSR_PE];
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
      if (state == ST_W_IER && done) init_done_o <= 1'b1;
      if (done && err)               slverr_o    <= 1'b1;
    end
  end

  peripheral_uart_apb_master_port #(
    .AW(APB_ADDR_WIDTH),
    .DW(APB_DATA_WIDTH)
  ) u_port (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .req     (req),
    .addr    (APB_ADDR_WIDTH'(UART_BASE) + APB_ADDR_WIDTH'(off)),
    .wdata   (APB_DATA_WIDTH'(wbyte)),
    .write   (write),
    .done    (done),
    .rdata   (rdata),
    .err     (err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

endmodule

// File: tb/tb_peripheral_uart_apb_host.sv
// Directed bench for peripheral_uart_apb_host with a scripted APB responder
// that logs every completed transfer as {write, offset, byte}.
module tb_peripheral_uart_apb_host;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_perr_o, rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        init_done_o, slverr_o;

  int checks = 0;
  int errors = 0;

  // responder script
  logic [7:0]  lsr_first = 8'h00;
  logic [7:0]  lsr_after = 8'h00;
  logic [7:0]  rbr_val = 8'h00;
  int          lsr_base = 0;
  int          wait_states = 0;
  int          slverr_idx = -1;
  // responder state (monitor-owned)
  int          lsr_reads = 0;
  int          log_n = 0;
  int          acc_cnt = 0;
  logic [11:0] log_e [0:8191];

  logic [11:0] exp_init [0:5] = '{12'hB83, 12'h81B, 12'h900, 12'hB03, 12'hA06, 12'h900};

  always #5 CLK = ~CLK;

  peripheral_uart_apb_host dut (
    .CLK(CLK), .RSTN(RSTN),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .init_done_o(init_done_o), .slverr_o(slverr_o)
  );

  assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_states);
  assign PSLVERR = PSEL && PENABLE && (log_n == slverr_idx);
  assign PRDATA  = {24'h0, (PADDR[2:0] == 3'd5) ? ((lsr_reads > lsr_base) ? lsr_after : lsr_first) : rbr_val};

  always @(posedge CLK) begin
    if (PSEL && PENABLE && PREADY) begin
      log_e[log_n % 8192] <= {PWRITE, PADDR[2:0], PWRITE ? PWDATA[7:0] : PRDATA[7:0]};
      log_n <= log_n + 1;
      if (!PWRITE && PADDR[2:0] == 3'd5) lsr_reads <= lsr_reads + 1;
      acc_cnt <= 0;
    end else if (PSEL && PENABLE) begin
      acc_cnt <= acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  function automatic logic [11:0] ent(input int i);
    return log_e[i % 8192];
  endfunction

  task automatic wait_log(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (log_n >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rx(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (rx_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push_byte(input logic [7:0] b, input int budget, output bit ok);
    ok = 1'b0;
    tx_data_i = b;
    tx_valid_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (tx_ready_o) begin @(posedge CLK); #1; ok = 1'b1; break; end
    end
  endtask

  task automatic reset_init(output bit ok);
    RSTN = 1'b0;
    tx_valid_i = 1'b0; tx_data_i = 8'h00; rx_ready_i = 1'b0;
    lsr_first = 8'h00; lsr_after = 8'h00; rbr_val = 8'h00; lsr_base = lsr_reads;
    wait_states = 0; slverr_idx = -1;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (init_done_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [59:0] outs;
    int start;
    bit ok;
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    outs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready_o, rx_valid_o, rx_data_o, rx_perr_o, init_done_o, slverr_o};
    checks++;
    if (outs !== 60'h0) begin errors++; $display("FAIL reset_values got %h exp 0", outs); end
    start = log_n;
    RSTN = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 12'h003, 32'h83}) begin
      errors++; $display("FAIL first_setup got %b%b%b %h %h exp 101 003 00000083", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    checks++;
    if (init_done_o !== 1'b0) begin errors++; $display("FAIL init_done_early got %b exp 0", init_done_o); end
    wait_log(start + 7, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout got %0d transfers exp 7", log_n - start); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ent(start + i) !== exp_init[i]) begin
        errors++; $display("FAIL init_write%0d got %h exp %h", i, ent(start + i), exp_init[i]);
      end
    end
    checks++;
    if (ent(start + 6) >> 8 !== 12'h5) begin errors++; $display("FAIL poll_after_init got %h exp 5xx", ent(start + 6)); end
    checks++;
    if (init_done_o !== 1'b1) begin errors++; $display("FAIL init_done got %b exp 1", init_done_o); end
  endtask

  task automatic test_back_to_back();
    int start;
    int n_ok;
    bit ok;
    reset_init(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_init got 0 exp 1"); end
    start = log_n;
    lsr_first = 8'h60; lsr_after = 8'h00; lsr_base = lsr_reads;
    n_ok = 0;
    for (int i = 0; i < 3; i++) begin
      push_byte(8'h41 + 8'(i), 100, ok);
      n_ok += int'(ok);
    end
    tx_valid_i = 1'b0;
    checks++;
    if (n_ok != 3) begin errors++; $display("FAIL b2b_accept got %0d exp 3", n_ok); end
    wait_log(start + 5, 100, ok);
    checks++;
    if (ent(start) >> 8 !== 12'h5) begin errors++; $display("FAIL b2b_poll got %h exp 5xx", ent(start)); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ent(start + 1 + i) !== 12'h841 + 12'(i)) begin
        errors++; $display("FAIL b2b_thr%0d got %h exp %h", i, ent(start + 1 + i), 12'h841 + 12'(i));
      end
    end
    checks++;
    if (ent(start + 4) >> 8 !== 12'h5) begin errors++; $display("FAIL b2b_repoll got %h exp 5xx", ent(start + 4)); end
  endtask

  task automatic test_credit();
    int start, mark, n_ok, n_wr, n_rd, n_bad;
    bit ok, saw_ready;
    reset_init(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL credit_init got 0 exp 1"); end
    start = log_n;
    lsr_first = 8'h20; lsr_after = 8'h00; lsr_base = lsr_reads;
    n_ok = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h10 + 8'(i), 100, ok);
      n_ok += int'(ok);
    end
    checks++;
    if (n_ok != 16) begin errors++; $display("FAIL credit_accept got %0d exp 16", n_ok); end
    tx_data_i = 8'h20; tx_valid_i = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (tx_ready_o) saw_ready = 1'b1;
    end
    checks++;
    if (saw_ready !== 1'b0) begin errors++; $display("FAIL credit_block got ready 1 exp 0"); end
    n_wr = 0; n_rd = 0; n_bad = 0;
    for (int i = start; i < log_n; i++) begin
      if (ent(i) >> 8 == 12'h8) begin
        if (ent(i) !== 12'h810 + 12'(n_wr)) n_bad++;
        n_wr++;
      end else if (n_wr == 16 && ent(i) >> 8 == 12'h5) begin
        n_rd++;
      end
    end
    checks++;
    if (n_wr != 16) begin errors++; $display("FAIL credit_thr_count got %0d exp 16", n_wr); end
    checks++;
    if (n_bad != 0) begin errors++; $display("FAIL credit_thr_data got %0d bad exp 0", n_bad); end
    checks++;
    if (n_rd < 3) begin errors++; $display("FAIL credit_repoll got %0d polls exp >=3", n_rd); end
    mark = log_n;
    lsr_base = lsr_reads;
    push_byte(8'h20, 100, ok);
    tx_valid_i = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL credit_17th_accept got 0 exp 1"); end
    wait_log(mark + 2, 50, ok);
    checks++;
    if ({ent(mark) >> 8, ent(mark + 1)} !== {12'h5, 12'h820}) begin
      errors++; $display("FAIL credit_17th got %h %h exp 5xx 820", ent(mark), ent(mark + 1));
    end
  endtask

  task automatic test_rx();
    int start, n_rbr;
    bit ok, stable;
    reset_init(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rx_init got 0 exp 1"); end
    start = log_n;
    rbr_val = 8'h5A; lsr_first = 8'h01; lsr_after = 8'h01; lsr_base = lsr_reads;
    wait_rx(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rx_valid_timeout got 0 exp 1"); end
    checks++;
    if ({rx_data_o, rx_perr_o} !== {8'h5A, 1'b0}) begin
      errors++; $display("FAIL rx_data got %h/%b exp 5a/0", rx_data_o, rx_perr_o);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL rx_hold got unstable exp stable"); end
    n_rbr = 0;
    for (int i = start; i < log_n; i++) if (ent(i) >> 8 == 12'h0) n_rbr++;
    checks++;
    if (n_rbr != 1) begin errors++; $display("FAIL rx_backpressure got %0d reads exp 1", n_rbr); end
    lsr_first = 8'h05; lsr_after = 8'h05; rbr_val = 8'h3C; lsr_base = lsr_reads;
    rx_ready_i = 1'b1;
    @(posedge CLK); #1;
    rx_ready_i = 1'b0;
    checks++;
    if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rx_clear got %b exp 0", rx_valid_o); end
    wait_rx(50, ok);
    checks++;
    if ({ok, rx_data_o, rx_perr_o} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++; $display("FAIL rx_perr got %b %h/%b exp 1 3c/1", ok, rx_data_o, rx_perr_o);
    end
    lsr_first = 8'h00; lsr_after = 8'h00;
    rx_ready_i = 1'b1;
    @(posedge CLK); #1;
    rx_ready_i = 1'b0;
  endtask

  task automatic test_wait_slverr();
    int start, n_acc, n_bad;
    bit ok, stable;
    RSTN = 1'b0;
    lsr_first = 8'h00; lsr_after = 8'h00; lsr_base = lsr_reads;
    wait_states = 3; slverr_idx = log_n + 2;
    repeat (2) @(negedge CLK);
    start = log_n;
    RSTN = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (PENABLE) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_access_timeout got 0 exp 1"); end
    n_acc = 0; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_acc++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 12'h003, 32'h83}) stable = 1'b0;
      if (PREADY) break;
      @(negedge CLK);
    end
    checks++;
    if (n_acc != 4) begin errors++; $display("FAIL wait_access_cycles got %0d exp 4", n_acc); end
    checks++;
    if (!stable) begin errors++; $display("FAIL wait_stable got unstable exp stable"); end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (init_done_o) begin ok = 1'b1; break; end
    end
    checks++;
    if ({ok, slverr_o} !== 2'b11) begin errors++; $display("FAIL slverr_init got %b%b exp 11", ok, slverr_o); end
    n_bad = 0;
    for (int i = 0; i < 6; i++) if (ent(start + i) !== exp_init[i]) n_bad++;
    checks++;
    if (n_bad != 0) begin errors++; $display("FAIL slverr_seq got %0d bad exp 0", n_bad); end
    repeat (20) @(negedge CLK);
    checks++;
    if ({slverr_o, init_done_o} !== 2'b11) begin errors++; $display("FAIL slverr_sticky got %b%b exp 11", slverr_o, init_done_o); end
  endtask

  task automatic test_reset_mid();
    logic [59:0] outs;
    int start, n_bad;
    bit ok, saw_ready;
    reset_init(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_init got 0 exp 1"); end
    wait_states = 2;
    lsr_first = 8'h20; lsr_after = 8'h00; lsr_base = lsr_reads;
    push_byte(8'h77, 100, ok);
    tx_valid_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (PSEL && PENABLE && PWRITE && PADDR[2:0] == 3'd0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_thr_access got 0 exp 1"); end
    #2;
    RSTN = 1'b0;
    #1;
    outs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, tx_ready_o, rx_valid_o, rx_data_o, rx_perr_o, init_done_o, slverr_o};
    checks++;
    if (outs !== 60'h0) begin errors++; $display("FAIL mid_reset_values got %h exp 0", outs); end
    start = log_n;
    lsr_first = 8'h00; lsr_base = lsr_reads; wait_states = 0;
    @(negedge CLK);
    RSTN = 1'b1;
    wait_log(start + 7, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_replay_timeout got %0d exp 7", log_n - start); end
    n_bad = 0;
    for (int i = 0; i < 6; i++) if (ent(start + i) !== exp_init[i]) n_bad++;
    if (ent(start + 6) >> 8 !== 12'h5) n_bad++;
    checks++;
    if (n_bad != 0) begin errors++; $display("FAIL mid_replay got %0d bad exp 0", n_bad); end
    tx_data_i = 8'h99; tx_valid_i = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (tx_ready_o) saw_ready = 1'b1;
    end
    tx_valid_i = 1'b0;
    checks++;
    if (saw_ready !== 1'b0) begin errors++; $display("FAIL mid_credit_cleared got ready 1 exp 0"); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_credit();
    test_rx();
    test_wait_slverr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
